// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares the single node-memory read port between NUM_REQ requesters.
// One grant per cycle. A tag pipeline of RD_LAT+1 stages follows each read to its return.
// Out-of-range reads are granted but never reach memory. They return zero data with err.
// Optional feature: define ARB_RR_EN for round-robin arbitration (default: fixed priority).
module mem_read_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [WORD_WIDTH-1:0]         rdata,
    output logic                          err,
    output logic [WORD_WIDTH-1:0]         mem_addr,
    output logic                          mem_rd_en,
    input  logic [WORD_WIDTH-1:0]         mem_rdata,
    output logic                          busy
);

    localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_STAGES = RD_LAT + 1;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             err;
    } tag_t;

    logic                  any_req;
    logic [IDX_W-1:0]      win_idx;
    logic [WORD_WIDTH-1:0] win_addr;
    logic                  in_range;
    tag_t                  tag_in;

    logic [NUM_REQ-1:0]    gnt_q;
    logic                  mem_rd_en_q;
    logic [WORD_WIDTH-1:0] mem_addr_q;
    logic [WORD_WIDTH-1:0] rdata_q;
    tag_t [NUM_STAGES-1:0] tag_q;

`ifdef ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;

    // Round-robin winner: search starts one past the last winner
    always_comb begin
        int unsigned cand;
        logic [IDX_W-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        any_req  = 1'b0;
        win_idx  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(ptr_q) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any_req && req[cand_idx]) begin
                any_req = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    // Pointer moves only on a grant; reset value makes requester 0 win first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (any_req) begin
            ptr_q <= win_idx;
        end
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_req = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Select the winner's address and classify it against the memory size
    always_comb begin
        win_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_addr = req_addr[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
        in_range     = (32'(win_addr) < MEM_DEPTH);
        tag_in.valid = any_req;
        tag_in.idx   = win_idx;
        tag_in.err   = any_req && !in_range;
    end

    // Grant pulse and memory strobe; mem_addr holds across out-of-range grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            gnt_q       <= any_req ? (NUM_REQ'(1) << win_idx) : '0;
            mem_rd_en_q <= any_req && in_range;
            if (any_req && in_range) begin
                mem_addr_q <= win_addr;
            end
        end
    end

    // Tag pipeline: stage k holds the read granted k+1 edges ago
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[NUM_STAGES-2:0], tag_in};
        end
    end

    // Capture returned data the edge before rvalid; out-of-range reads return zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (tag_q[RD_LAT-1].valid) begin
            rdata_q <= tag_q[RD_LAT-1].err ? '0 : mem_rdata;
        end
    end

    // Return strobes decoded from the last tag stage; busy covers every stage
    always_comb begin
        rvalid = '0;
        if (tag_q[RD_LAT].valid) begin
            rvalid[tag_q[RD_LAT].idx] = 1'b1;
        end
        err  = tag_q[RD_LAT].valid & tag_q[RD_LAT].err;
        busy = 1'b0;
        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

    assign gnt       = gnt_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Testbench for mem_read_arbiter: directed scenarios plus random traffic, checked by a
// scoreboard fed from a reference model of the arbitration and return rules.
module tb_mem_read_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int W         = 16;
    localparam int RD_LAT    = 2;
    localparam int MEM_DEPTH = 1024;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int PI        = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*W-1:0]   req_addr;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     rvalid;
    logic [W-1:0]           rdata;
    logic                   err;
    logic [W-1:0]           mem_addr;
    logic                   mem_rd_en;
    logic [W-1:0]           mem_rdata;
    logic                   busy;

    mem_read_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .WORD_WIDTH (W),
        .RD_LAT     (RD_LAT),
        .MEM_DEPTH  (MEM_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data for a strobe is presented RD_LAT-1 edges after it appears
    logic [W-1:0] mem_arr [MEM_DEPTH];
    logic         pv [RD_LAT];
    logic [W-1:0] pa [RD_LAT];

    always @(posedge clk) begin
        pv[0] <= mem_rd_en;
        pa[0] <= mem_addr;
        for (int k = 1; k < RD_LAT; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
    end

    assign mem_rdata = (RD_LAT == 1) ? (mem_rd_en ? mem_arr[mem_addr[AW-1:0]] : 16'hDEAD)
                                     : (pv[PI] ? mem_arr[pa[PI][AW-1:0]] : 16'hDEAD);

    // Scoreboard state
    typedef struct { int cyc; int idx; bit inr; } gnt_t;
    typedef struct { int due; int idx; logic [W-1:0] data; bit err; } ret_t;

    gnt_t               gq[$];
    ret_t               rq[$];
    int                 cyc = 0;
    int                 ptr = NUM_REQ - 1;
    logic [W-1:0]       exp_mem_addr = '0;
    logic [NUM_REQ-1:0] model_gnt = '0;
    int                 n_checks = 0;
    int                 n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)",
                     name, act, exp, cyc, $time);
        end
    endfunction

    // Arbitration rule taken straight from the requester-selection policy
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
`ifdef ARB_RR_EN
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[k]) return k;
        end
`endif
        return -1;
    endfunction

    // Reference model: at each edge decide the winner and queue its expected responses
    initial forever begin
        int           w;
        logic [W-1:0] a;
        bit           inr;
        gnt_t         ge;
        ret_t         re;
        @(posedge clk);
        if (rst_n) begin
            cyc++;
            model_gnt = '0;
            w = pick(req, ptr);
            if (w >= 0) begin
                a   = req_addr[w*W +: W];
                inr = (int'(a) < MEM_DEPTH);
                ptr = w;
                model_gnt[w] = 1'b1;
                if (inr) exp_mem_addr = a;
                ge.cyc = cyc; ge.idx = w; ge.inr = inr;
                re.due = cyc + RD_LAT; re.idx = w; re.err = !inr;
                re.data = inr ? mem_arr[a[AW-1:0]] : '0;
                gq.push_back(ge);
                rq.push_back(re);
            end
        end
    end

    // Reset discards everything in flight
    initial forever begin
        @(negedge rst_n);
        gq.delete();
        rq.delete();
        ptr          = NUM_REQ - 1;
        exp_mem_addr = '0;
        model_gnt    = '0;
    end

    // Monitor: compare every cycle on the falling edge
    initial forever begin
        logic [NUM_REQ-1:0] exp_g;
        logic [NUM_REQ-1:0] exp_rv;
        bit                 exp_en;
        gnt_t               ge;
        ret_t               re;
        @(negedge clk);
        if (!rst_n) begin
            check("rst_gnt", 32'(gnt), 0);
            check("rst_rvalid", 32'(rvalid), 0);
            check("rst_rdata", 32'(rdata), 0);
            check("rst_err", 32'(err), 0);
            check("rst_mem_addr", 32'(mem_addr), 0);
            check("rst_mem_rd_en", 32'(mem_rd_en), 0);
            check("rst_busy", 32'(busy), 0);
        end else begin
            exp_g  = '0;
            exp_en = 1'b0;
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                ge = gq.pop_front();
                exp_g[ge.idx] = 1'b1;
                exp_en = ge.inr;
            end
            check("gnt", 32'(gnt), 32'(exp_g));
            check("mem_rd_en", 32'(mem_rd_en), 32'(exp_en));
            check("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
            check("busy", 32'(busy), 32'(rq.size() != 0));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                re = rq.pop_front();
                exp_rv = '0;
                exp_rv[re.idx] = 1'b1;
                check("rvalid", 32'(rvalid), 32'(exp_rv));
                check("rdata", 32'(rdata), 32'(re.data));
                check("err", 32'(err), 32'(re.err));
            end else begin
                check("rvalid_idle", 32'(rvalid), 0);
                check("err_idle", 32'(err), 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_addr();
        int unsigned r;
        r = $urandom_range(15);
        if (r == 0) return W'(MEM_DEPTH);
        if (r == 1) return W'(MEM_DEPTH - 1);
        if (r == 2) return W'($urandom_range(16'hFFFF, MEM_DEPTH));
        return W'($urandom_range(MEM_DEPTH - 1));
    endfunction

    // Granted requesters listed in keep get a fresh address; the others drop req
    task automatic follow_grants(input logic [NUM_REQ-1:0] keep);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && model_gnt[i]) begin
                if (keep[i]) req_addr[i*W +: W] = rand_addr() % W'(MEM_DEPTH);
                else req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem_arr[i] = W'($urandom);
        mem_arr[16'h148] = 16'h00A5;
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Single read from requester 1
        tick();
        req[1] = 1'b1; req_addr[1*W +: W] = 16'h0148;
        tick();
        req[1] = 1'b0;
        repeat (5) tick();

        // Out-of-range read at exactly MEM_DEPTH
        req[3] = 1'b1; req_addr[3*W +: W] = W'(MEM_DEPTH);
        tick();
        req[3] = 1'b0;
        repeat (5) tick();

        // Back-to-back reads from requester 0
        req[0] = 1'b1; req_addr[0 +: W] = 16'h0048;
        tick();
        req_addr[0 +: W] = 16'h0049;
        tick();
        req_addr[0 +: W] = 16'h004A;
        tick();
        req[0] = 1'b0;
        repeat (5) tick();

        // Full contention for 8 cycles
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*W +: W] = W'(16'h100 + i);
        req = '1;
        for (int n = 0; n < 8; n++) begin
            tick();
            follow_grants('1);
        end
        req = '0;
        repeat (5) tick();

        // Requesters 0 and 2 held; requester 0 drops after 4 cycles
        req[0] = 1'b1; req_addr[0 +: W] = 16'h0010;
        req[2] = 1'b1; req_addr[2*W +: W] = 16'h0020;
        for (int n = 0; n < 4; n++) begin
            tick();
            follow_grants(4'b0101);
        end
        req[0] = 1'b0;
        for (int n = 0; n < 8 && req[2]; n++) begin
            tick();
            follow_grants('0);
        end
        req = '0;
        repeat (5) tick();

        // Reset one cycle after a grant to requester 2
        req[2] = 1'b1; req_addr[2*W +: W] = 16'h02C3;
        tick();
        req[2] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_mem_addr", 32'(mem_addr), 0);
        check("midrst_rvalid", 32'(rvalid), 0);
        check("midrst_gnt", 32'(gnt), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        req[0] = 1'b1; req_addr[0 +: W] = 16'h0030;
        req[2] = 1'b1; req_addr[2*W +: W] = 16'h0031;
        for (int n = 0; n < 6 && req != '0; n++) begin
            tick();
            follow_grants('0);
        end
        req = '0;
        repeat (5) tick();

        // Random traffic obeying the hold-until-grant rule
        for (int n = 0; n < 400; n++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    if (model_gnt[i]) begin
                        if ($urandom_range(1) == 1) req_addr[i*W +: W] = rand_addr();
                        else req[i] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    req_addr[i*W +: W] = rand_addr();
                end
            end
        end
        req = '0;
        repeat (RD_LAT + 6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares the single node-memory read port between up to NUM_REQ requesters (reward builder, action selector, Q-update, neighbour-table walker). Each requester presents a word address; the arbiter grants one request per cycle, drives the memory address, tracks the in-flight read through the fixed memory latency, and returns the data to the originating requester with a one-hot valid. It sits between the learning-stage blocks and the memory model, replacing the direct ad-hoc address muxing between stages.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- WORD_WIDTH, 16: address and data width
- RD_LAT, 2: cycles from mem_rd_en high to mem_rdata valid (1..4)
- MEM_DEPTH, 1024: legal address range 0..MEM_DEPTH-1

- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req  in  NUM_REQ  per-requester read request, level
- req_addr  in  NUM_REQ*WORD_WIDTH  requester i address at bits [i*WORD_WIDTH +: WORD_WIDTH]
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: address of that requester accepted
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse: rdata belongs to that requester
- rdata  out  WORD_WIDTH  returned read data, shared by all requesters
- err  out  1  one-cycle pulse alongside rvalid when the read was out of range
- mem_addr  out  WORD_WIDTH  registered memory address
- mem_rd_en  out  1  registered memory read strobe
- mem_rdata  in  WORD_WIDTH  memory read data
- busy  out  1  high while any read is in flight

## Operation
- Requester holds req high and req_addr stable until it sees its gnt; addr is captured at the edge that raises gnt.
- Keeping req high after gnt requests a new read (back-to-back); the requester updates req_addr in the gnt cycle.
- Each cycle at most one request is accepted; throughput one read per cycle.
- Arbitration (see Configuration): winner chosen among req bits sampled at the edge.
- Out-of-range addr (>= MEM_DEPTH): granted normally, mem_rd_en stays 0, mem_addr holds previous value, returned rdata = 0, err = 1 with the rvalid.
- Tag pipeline of RD_LAT+1 stages carries {valid, requester index, err}; busy = OR of stage valids.
- No request dropped: an unselected requester keeps req high and waits.
- Reset values: gnt=0, rvalid=0, rdata=0, err=0, mem_addr=0, mem_rd_en=0, busy=0, round-robin pointer = NUM_REQ-1 (requester 0 wins first).
- Reset mid-operation: all in-flight tags discarded; no rvalid is produced for them after release.

## Timing
- Edge E0: req sampled, winner chosen; after E0: gnt[w]=1, mem_addr, mem_rd_en=1 for one cycle.
- mem_rdata valid in cycle E0+RD_LAT; registered into rdata at the next edge.
- rvalid[w] high in cycle E0+RD_LAT+1 (RD_LAT=2: gnt cycle 1, rvalid cycle 3 after E0).
- Returns arrive in grant order; one rvalid per grant, never two in one cycle.
- req raised and dropped between edges is not seen.
- gnt and rvalid may be high in the same cycle for different or the same requester.

## Configuration
- ARB_RR_EN defined: round-robin; search starts at pointer+1 modulo NUM_REQ, pointer updates to the winner on every grant only; all requesting gives 0,1,2,3,0,...
- ARB_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent; requester 0 holding req continuously starves the others.

## Test plan
- Single read: reset release, req[1]=1, addr 0x148, memory holds 0x00A5 -> gnt[1] next cycle, mem_addr=0x148, rvalid[1] with rdata=0x00A5 RD_LAT+1 cycles after the grant edge, busy low afterwards.
- Contention (ARB_RR_EN): all four req held for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3, rvalid in same order, each with its own data.
- Fixed priority (no ARB_RR_EN): req[0] and req[2] held 4 cycles -> gnt[0] four times, gnt[2] never, then gnt[2] after req[0] drops.
- Out of range: req[3], addr 1024 -> gnt[3], mem_rd_en stays 0, rvalid[3] with rdata=0 and err=1.
- Back-to-back: req[0] held, addrs 0x48, 0x49, 0x4A on consecutive cycles -> three gnt pulses, three consecutive rvalid[0] with matching data.
- Reset mid-flight: reset low one cycle after gnt[2] -> all outputs 0 immediately, no rvalid[2] after release, next grant goes to requester 0.
